fetch_unit: RTL

//  Program counter plus instruction register stage directly upstream of the control unit.
//  On the CU instruction-load pulse it fetches one 16-bit word from instruction memory over a
//  req/ack handshake, latches it into IR and drives it as the CU instruction input.

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit_if.sv | 12 +
 rtl/fetch_pc_next.sv | 35 +++
 rtl/fetch_unit_svamod.sv | 31 +++
 rtl/fetch_unit.sv | 109 ++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch stage: PC-select command, fetch FSM states
// and the opcode loaded into IR when instruction memory never answers.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        PS_HOLD = 2'b00,
        PS_INC  = 2'b01,
        PS_BRR  = 2'b10,
        PS_JMP  = 2'b11
    } pc_sel_t;

    typedef enum logic [1:0] {
        F_IDLE = 2'b00,
        F_REQ  = 2'b01,
        F_ERR  = 2'b10
    } fetch_state_t;

    localparam logic [15:0] ILLEGAL_INS = 16'hFFFF;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/acknowledge bus between the fetch unit (master) and memory (slave).
interface fetch_unit_if #(
    parameter int AW = 16
) ();
    logic          req;
    logic [AW-1:0] addr;
    logic          ack;
    logic [15:0]   rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_pc_next.sv
// Combinational next-PC selection: hold, increment, relative branch or absolute jump.
// The branch offset is the 6-bit field {ir[8:6], ir[2:0]}, sign-extended to the PC width.
module fetch_pc_next
    import fetch_unit_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic [AW-1:0] pc,
    input  pc_sel_t       ps,
    input  logic [15:0]   ir,
    input  logic [AW-1:0] ra,
    output logic [AW-1:0] pc_next
);

    logic [5:0]    br_off;
    logic [AW-1:0] br_off_ext;
    logic          unused_ir_bits;

    assign br_off         = {ir[8:6], ir[2:0]};
    assign br_off_ext     = {{(AW-6){br_off[5]}}, br_off};
    assign unused_ir_bits = ^{ir[15:9], ir[5:3]};

    // Select the next PC according to the command; additions wrap at the PC width
    always_comb begin
        pc_next = pc;
        case (ps)
            PS_HOLD: pc_next = pc;
            PS_INC:  pc_next = pc + AW'(1);
            PS_BRR:  pc_next = pc + br_off_ext;
            PS_JMP:  pc_next = ra;
            default: pc_next = pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit_svamod.sv
// Assertion companion for fetch_unit: no unknowns out of reset, reset values while reset is
// held, and a request with its address held steady until acknowledged or timed out.
module fetch_unit_svamod #(
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          rst,
    input logic          req,
    input logic [AW-1:0] addr,
    input logic          ack,
    input logic [15:0]   ins,
    input logic [AW-1:0] pc,
    input logic          stall,
    input logic          err
);

    a_xcheck : assert property (@(posedge clk) disable iff (rst)
        !$isunknown({req, addr, ins, pc, stall, err}))
        else $error("fetch_unit: unknown value on an output");

    a_reset_vals : assert property (@(posedge clk)
        (rst && $past(rst)) |-> (!req && addr == '0 && ins == 16'h0000 && pc == RESET_PC
                                 && !stall && !err))
        else $error("fetch_unit: wrong value while reset held");

    a_req_stable : assert property (@(posedge clk) disable iff (rst)
        (req && !ack) |=> ((req && $stable(addr)) || err))
        else $error("fetch_unit: request dropped or address moved before ack");

endmodule

// File: rtl/fetch_unit.sv
// Program counter and instruction register stage feeding the control unit.
// A load pulse starts one memory fetch; the PC command is only honoured while idle, and a
// fetch that is never acknowledged parks the unit in a terminal error state with an
// illegal opcode in IR so the control unit halts.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            TMO_CYC  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             il_in,
    input  logic [1:0]       ps_in,
    input  logic [AW-1:0]    ra_in,
    fetch_unit_if.master     imem,
    output logic [15:0]      ins_out,
    output logic [AW-1:0]    pc_out,
    output logic             stall_out,
    output logic             tmo_err_out
);

    localparam int             TCW      = $clog2(TMO_CYC + 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TMO_CYC - 1);
    localparam logic [TCW-1:0] TMO_SAT  = TCW'(TMO_CYC);

    fetch_state_t   state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [15:0]    ir_q, ir_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic           tmo_err_q, tmo_err_d;
    logic [AW-1:0]  pc_upd;

    fetch_pc_next #(.AW(AW)) u_pc_next (
        .pc      (pc_q),
        .ps      (pc_sel_t'(ps_in)),
        .ir      (ir_q),
        .ra      (ra_in),
        .pc_next (pc_upd)
    );

    // State register; reset abandons any fetch in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= F_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            addr_q    <= '0;
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            addr_q    <= addr_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    // Fetch sequencing: capture the pre-update PC as the address, then wait for ack or timeout
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        addr_d    = addr_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_err_d = tmo_err_q;
        case (state_q)
            F_IDLE: begin
                pc_d = pc_upd;
                if (il_in) begin
                    state_d   = F_REQ;
                    addr_d    = pc_q;
                    tmo_cnt_d = '0;
                end
            end
            F_REQ: begin
                if (imem.ack) begin
                    ir_d    = imem.rdata;
                    pc_d    = pc_q + AW'(1);
                    state_d = F_IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    ir_d      = ILLEGAL_INS;
                    tmo_err_d = 1'b1;
                    state_d   = F_ERR;
                end else if (tmo_cnt_q != TMO_SAT) begin
                    tmo_cnt_d = tmo_cnt_q + TCW'(1);
                end
            end
            F_ERR: begin
                state_d = F_ERR;
            end
            default: begin
                state_d = F_IDLE;
            end
        endcase
    end

    assign imem.req    = (state_q == F_REQ);
    assign imem.addr   = addr_q;
    assign stall_out   = (state_q == F_REQ);
    assign ins_out     = ir_q;
    assign pc_out      = pc_q;
    assign tmo_err_out = tmo_err_q;

endmodule
